// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the alarm clock time datapath
package clock_pkg;

  // Count direction encoding on the dir input
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Default moduli and field widths for a 24 h time-of-day counter
  localparam int S_MOD_DEF = 60;
  localparam int M_MOD_DEF = 60;
  localparam int H_MOD_DEF = 24;
  localparam int S_W_DEF   = 6;
  localparam int M_W_DEF   = 6;
  localparam int H_W_DEF   = 5;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter stage with terminal-count output
module mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] L_MAX = W'(MOD - 1);
  localparam logic [W-1:0] L_ONE = W'(1);

  logic [W-1:0] r_q;

  // Load has priority over counting; count wraps exactly at 0 / MOD-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= d;
    end else if (en) begin
      if (dn == DIR_DOWN) begin
        r_q <= (r_q == '0) ? L_MAX : r_q - L_ONE;
      end else begin
        r_q <= (r_q == L_MAX) ? '0 : r_q + L_ONE;
      end
    end
  end

  assign q  = r_q;
  // Terminal count: this stage wraps on the current enable, so the next stage steps
  assign tc = en & ((dn == DIR_DOWN) ? (r_q == '0) : (r_q == L_MAX));

endmodule

// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - cascaded hh:mm:ss up/down counter with load and set buttons
module hms_time_counter
  import clock_pkg::*;
#(
  parameter int S_MOD     = S_MOD_DEF,
  parameter int M_MOD     = M_MOD_DEF,
  parameter int H_MOD     = H_MOD_DEF,
  parameter int S_W       = S_W_DEF,
  parameter int M_W       = M_W_DEF,
  parameter int H_W       = H_W_DEF,
  parameter bit STOP_AT_0 = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           run,
  input  logic           dir,
  input  logic           load,
  input  logic [H_W-1:0] ld_h,
  input  logic [M_W-1:0] ld_m,
  input  logic [S_W-1:0] ld_s,
  input  logic           inc_m,
  input  logic           inc_h,
  output logic [H_W-1:0] hr,
  output logic [M_W-1:0] mn,
  output logic [S_W-1:0] sec,
  output logic           min_wrap,
  output logic           hr_wrap,
  output logic           day_wrap,
  output logic           zero,
  output logic           zero_hit,
  output logic           load_err
);

  localparam logic [S_W-1:0] L_S_ONE = S_W'(1);

  logic [H_W-1:0] w_hr;
  logic [M_W-1:0] w_mn;
  logic [S_W-1:0] w_sec;
  logic           w_tc_s, w_tc_m, w_tc_h;
  logic           w_ld_ok, w_ld_go, w_inc, w_do_inc, w_do_tick, w_hold_zero, w_dn;
  logic           w_en_s, w_en_m, w_en_h, w_ld_sec;
  logic [S_W-1:0] w_d_sec;
  logic           w_zero;

  logic r_min_wrap, r_hr_wrap, r_day_wrap, r_zero_hit, r_load_err;

  assign w_zero      = (w_hr == '0) && (w_mn == '0) && (w_sec == '0);
  assign w_ld_ok     = (int'(ld_s) < S_MOD) && (int'(ld_m) < M_MOD) && (int'(ld_h) < H_MOD);
  assign w_ld_go     = load & w_ld_ok;
  assign w_inc       = inc_m | inc_h;
  // Set buttons only act when no load is present; ticks only when neither is present
  assign w_do_inc    = !load & w_inc;
  assign w_hold_zero = STOP_AT_0 && (dir == DIR_DOWN) && w_zero;
  assign w_do_tick   = !load & !w_inc & tick & run & !w_hold_zero;
  // Set buttons always count up, regardless of dir
  assign w_dn        = w_do_tick & (dir == DIR_DOWN);

  // Seconds step only on ticks; inc_m clears seconds through the load path
  assign w_en_s   = w_do_tick;
  assign w_en_m   = w_do_tick ? w_tc_s : (w_do_inc & inc_m);
  assign w_en_h   = w_do_tick ? w_tc_m : (w_do_inc & inc_h);
  assign w_ld_sec = w_ld_go | (w_do_inc & inc_m);
  assign w_d_sec  = load ? ld_s : '0;

  mod_counter #(.MOD(S_MOD), .W(S_W)) u_sec (
    .clk(clk), .rst(rst), .en(w_en_s), .dn(w_dn), .ld(w_ld_sec), .d(w_d_sec),
    .q(w_sec), .tc(w_tc_s)
  );

  mod_counter #(.MOD(M_MOD), .W(M_W)) u_min (
    .clk(clk), .rst(rst), .en(w_en_m), .dn(w_dn), .ld(w_ld_go), .d(ld_m),
    .q(w_mn), .tc(w_tc_m)
  );

  mod_counter #(.MOD(H_MOD), .W(H_W)) u_hr (
    .clk(clk), .rst(rst), .en(w_en_h), .dn(w_dn), .ld(w_ld_go), .d(ld_h),
    .q(w_hr), .tc(w_tc_h)
  );

  // Event pulses registered alongside the count so they line up with the new value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_wrap <= 1'b0;
      r_hr_wrap  <= 1'b0;
      r_day_wrap <= 1'b0;
      r_zero_hit <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_min_wrap <= w_do_tick & w_tc_s;
      r_hr_wrap  <= w_do_tick & w_tc_m;
      r_day_wrap <= w_do_tick & w_tc_h;
      r_zero_hit <= w_dn && (w_hr == '0) && (w_mn == '0) && (w_sec == L_S_ONE);
      r_load_err <= load & !w_ld_ok;
    end
  end

  assign hr       = w_hr;
  assign mn       = w_mn;
  assign sec      = w_sec;
  assign zero     = w_zero;
  assign min_wrap = r_min_wrap;
  assign hr_wrap  = r_hr_wrap;
  assign day_wrap = r_day_wrap;
  assign zero_hit = r_zero_hit;
  assign load_err = r_load_err;

endmodule
